step_ctrl: RTL and testbench

- Sits directly downstream of the board clock divider, which emits a slow square wave.
- Converts that wave into single-cycle `step_en` pulses in the fast `clk` domain. The branch-predictor core uses `step_en` as its clock enable.
- Adds board-level run/pause and single-step control from two push buttons, so the predictor can be watched one branch at a time on LEDs/7-seg.

---
 rtl/step_ctrl_pkg.sv | 12 +
 rtl/btn_debounce.sv | 67 ++++++
 rtl/step_ctrl.sv | 120 ++++++++++++
 tb/tb_step_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: FSM state type and structural limits shared by step_ctrl and btn_debounce.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2
  } step_state_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw push button, accepts a level after DEBOUNCE_CYCLES
// stable cycles and emits a one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_armed;
  logic                   r_press;
  logic                   w_sync_out;
  logic                   w_differs;
  logic                   w_flip;

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("btn_debounce: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_differs  = w_sync_out ^ r_level;
  assign w_flip     = w_differs & (r_cnt == CNT_MAX);

  // r_armed stays low until a released button has been seen through a full
  // synchronizer, so a button held across reset never produces a press.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      if (r_fill[SYNC_STAGES-1] && !w_sync_out) begin
        r_armed <= 1'b1;
      end
      if (!w_differs || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
      r_press <= w_flip & ~r_level & r_armed;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: turns the divided slow clock into one-cycle step enables with run/pause and
// single-step buttons. Define STEP_LIMIT_EN to add the step_limit auto-pause input.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int STEP_CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slow_clk_in,
  input  logic                  btn_run,
  input  logic                  btn_step,
`ifdef STEP_LIMIT_EN
  input  logic [STEP_CNT_W-1:0] step_limit,
`endif
  output logic                  step_en,
  output logic                  running,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam logic [STEP_CNT_W-1:0] CNT_ONE = STEP_CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_slow_sync;
  logic                   r_slow_prev;
  step_state_e            r_state;
  step_state_e            w_next_state;
  logic                   r_step_en;
  logic                   r_running;
  logic [STEP_CNT_W-1:0]  r_step_count;
  logic                   w_tick;
  logic                   w_run_press;
  logic                   w_step_press;
  logic                   w_limit_hit;
  logic                   w_fire;

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("step_ctrl: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_run_db (
    .i_clk  (clk),
    .i_reset(reset),
    .i_btn  (btn_run),
    .o_press(w_run_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_step_db (
    .i_clk  (clk),
    .i_reset(reset),
    .i_btn  (btn_step),
    .o_press(w_step_press)
  );

  assign w_tick = r_slow_sync[SYNC_STAGES-1] & ~r_slow_prev;

`ifdef STEP_LIMIT_EN
  // r_step_count has not yet counted the pulse being issued, hence the +1.
  assign w_limit_hit = w_tick && (step_limit != '0) && ((r_step_count + CNT_ONE) == step_limit);
`else
  assign w_limit_hit = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_fire       = 1'b0;
    case (r_state)
      S_PAUSE: begin
        if (w_run_press) begin
          w_next_state = S_RUN;
        end else if (w_step_press) begin
          w_next_state = S_STEP;
        end
      end
      S_RUN: begin
        w_fire = w_tick;
        if (w_run_press || w_limit_hit) begin
          w_next_state = S_PAUSE;
        end
      end
      S_STEP: begin
        w_fire       = 1'b1;
        w_next_state = S_PAUSE;
      end
      default: w_next_state = S_PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slow_sync  <= '0;
      r_slow_prev  <= 1'b0;
      r_state      <= S_PAUSE;
      r_step_en    <= 1'b0;
      r_running    <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_slow_sync <= {r_slow_sync[SYNC_STAGES-2:0], slow_clk_in};
      r_slow_prev <= r_slow_sync[SYNC_STAGES-1];
      r_state     <= w_next_state;
      r_step_en   <= w_fire;
      r_running   <= (w_next_state == S_RUN);
      if (r_step_en) begin
        r_step_count <= r_step_count + CNT_ONE;
      end
    end
  end

  assign step_en    = r_step_en;
  assign running    = r_running;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed scenarios plus randomized stimulus against a behavioural model of step_ctrl.
`timescale 1ns/1ps
module tb_step_ctrl;

  localparam int DEB     = 4;
  localparam int SYNC    = 2;
  localparam int CW      = 8;
  localparam int CNT_MOD = 256;
  localparam int HIST    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          slow_clk_in = 1'b0;
  logic          btn_run = 1'b0;
  logic          btn_step = 1'b0;
  logic          step_en;
  logic          running;
  logic [CW-1:0] step_count;
`ifdef STEP_LIMIT_EN
  logic [CW-1:0] step_limit = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int run_seen = 0;

  always #5 clk = ~clk;

  step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .STEP_CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .slow_clk_in(slow_clk_in),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
`ifdef STEP_LIMIT_EN
    .step_limit (step_limit),
`endif
    .step_en    (step_en),
    .running    (running),
    .step_count (step_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per clock edge (index 0 = newest); debounced view as windows of sync values.
  bit          slow_h[$], run_h[$], step_h[$];
  bit          run_sq[$], step_sq[$];
  bit          m_run, m_single, m_step_en, m_tick, m_rpress, m_spress;
  bit          run_lvl, step_lvl, run_arm, step_arm;
  int unsigned m_count;

  task automatic model_clear();
    slow_h.delete(); run_h.delete(); step_h.delete();
    run_sq.delete(); step_sq.delete();
    m_run = 0; m_single = 0; m_step_en = 0; m_tick = 0; m_rpress = 0; m_spress = 0;
    run_lvl = 0; step_lvl = 0; run_arm = 0; step_arm = 0;
    m_count = 0;
  endtask

  task automatic model_step();
    bit          fire, s, all_diff;
    int unsigned lim;
`ifdef STEP_LIMIT_EN
    lim = step_limit;
`else
    lim = 0;
`endif
    fire = (m_run && m_tick) || m_single;
    if (m_single) m_single = 1'b0;
    else if (m_run) begin
      if (m_rpress || (m_tick && lim != 0 && ((m_count + 1) % CNT_MOD) == lim)) m_run = 1'b0;
    end else if (m_rpress) m_run = 1'b1;
    else if (m_spress) m_single = 1'b1;
    if (m_step_en) m_count = (m_count + 1) % CNT_MOD;
    m_step_en = fire;

    // run button: accepted level flips after DEB consecutive differing sync values
    s = (run_h.size() >= SYNC) ? run_h[SYNC-1] : 1'b0;
    run_sq.push_front(s);
    if (run_sq.size() > DEB) void'(run_sq.pop_back());
    all_diff = (run_sq.size() == DEB);
    foreach (run_sq[i]) if (run_sq[i] == run_lvl) all_diff = 0;
    m_rpress = all_diff && !run_lvl && run_arm;
    if (all_diff) run_lvl = !run_lvl;
    if (run_h.size() >= SYNC && !s) run_arm = 1;

    s = (step_h.size() >= SYNC) ? step_h[SYNC-1] : 1'b0;
    step_sq.push_front(s);
    if (step_sq.size() > DEB) void'(step_sq.pop_back());
    all_diff = (step_sq.size() == DEB);
    foreach (step_sq[i]) if (step_sq[i] == step_lvl) all_diff = 0;
    m_spress = all_diff && !step_lvl && step_arm;
    if (all_diff) step_lvl = !step_lvl;
    if (step_h.size() >= SYNC && !s) step_arm = 1;

    slow_h.push_front(slow_clk_in);
    run_h.push_front(btn_run);
    step_h.push_front(btn_step);
    if (slow_h.size() > HIST) void'(slow_h.pop_back());
    if (run_h.size() > HIST) void'(run_h.pop_back());
    if (step_h.size() > HIST) void'(step_h.pop_back());
    m_tick = ((slow_h.size() >= SYNC) ? slow_h[SYNC-1] : 1'b0) &&
             !((slow_h.size() > SYNC) ? slow_h[SYNC] : 1'b0);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("step_en", 32'(step_en), 32'(m_step_en));
        chk("running", 32'(running), 32'(m_run));
        chk("step_count", 32'(step_count), m_count);
        if (step_en) pulses++;
        if (running) run_seen = 1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic press(input bit run, input bit stp, input int hold);
    btn_run = run; btn_step = stp;
    cycles(hold);
    btn_run = 0; btn_step = 0;
  endtask

  task automatic tick_once(input int half);
    slow_clk_in = 1'b1; cycles(half);
    slow_clk_in = 1'b0; cycles(half);
  endtask

  initial begin
    int n;
    int h_slow, h_run, h_step;
    cycles(2);
    chk("rst_step_en", 32'(step_en), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_count", 32'(step_count), 0);
    reset = 1'b0;

    // paused: ticks ignored
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) slow_clk_in = ~slow_clk_in;
      cycles(1);
    end
    slow_clk_in = 1'b0;
    cycles(6);
    chk("t1_pulses", pulses, 0);
    chk("t1_count", 32'(step_count), 0);

    // run with five ticks; first tick latency
    press(1, 0, 6);
    cycles(8);
    chk("t2_running", 32'(running), 1);
    pulses = 0;
    slow_clk_in = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (step_en) break;
    end
    chk("t2_latency", n, SYNC + 1);
    cycles(9);
    slow_clk_in = 1'b0;
    cycles(10);
    repeat (4) tick_once(10);
    cycles(4);
    chk("t2_pulses", pulses, 5);
    chk("t2_count", 32'(step_count), 5);

    // bouncing step button then a real press
    sync_reset();
    cycles(6);
    pulses = 0; run_seen = 0;
    btn_step = 1; cycles(1); btn_step = 0; cycles(1);
    btn_step = 1; cycles(1); btn_step = 0; cycles(1);
    press(0, 1, 6);
    cycles(12);
    chk("t3_pulses", pulses, 1);
    chk("t3_count", 32'(step_count), 1);
    chk("t3_run_seen", run_seen, 0);

    // both buttons together: run wins
    sync_reset();
    cycles(6);
    pulses = 0;
    press(1, 1, 6);
    cycles(12);
    chk("t4_running", 32'(running), 1);
    chk("t4_pulses", pulses, 0);

    // step_count wrap
    repeat (255) tick_once(2);
    cycles(4);
    chk("t5_count_255", 32'(step_count), 255);
    tick_once(3);
    cycles(3);
    chk("t5_count_wrap", 32'(step_count), 0);
    tick_once(3);
    cycles(3);

    // asynchronous reset mid-debounce with button held through release
    btn_run = 1;
    cycles(3);
    #2 reset = 1'b1;
    #1;
    chk("arst_step_en", 32'(step_en), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_count", 32'(step_count), 0);
    @(negedge clk);
    reset = 1'b0;
    cycles(20);
    chk("held_no_press", 32'(running), 0);
    btn_run = 0;
    cycles(8);
    press(1, 0, 6);
    cycles(8);
    chk("repress_running", 32'(running), 1);

`ifdef STEP_LIMIT_EN
    sync_reset();
    cycles(6);
    step_limit = 8'd3;
    pulses = 0;
    press(1, 0, 6);
    cycles(8);
    repeat (6) tick_once(4);
    cycles(4);
    chk("lim_pulses", pulses, 3);
    chk("lim_count", 32'(step_count), 3);
    chk("lim_running", 32'(running), 0);
    step_limit = 8'd0;
`endif

    // randomized stimulus
    sync_reset();
    cycles(4);
`ifdef STEP_LIMIT_EN
    step_limit = 8'($urandom_range(0, 6));
`endif
    h_slow = 1; h_run = 10; h_step = 15;
    for (int i = 0; i < 4000; i++) begin
      h_slow--; h_run--; h_step--;
      if (h_slow <= 0) begin
        slow_clk_in = ~slow_clk_in;
        h_slow = int'($urandom_range(1, 6));
      end
      if (h_run <= 0) begin
        btn_run = ~btn_run;
        h_run = btn_run ? int'($urandom_range(1, 8)) : int'($urandom_range(5, 60));
      end
      if (h_step <= 0) begin
        btn_step = ~btn_step;
        h_step = btn_step ? int'($urandom_range(1, 8)) : int'($urandom_range(5, 40));
      end
      cycles(1);
    end
    btn_run = 0; btn_step = 0;
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
